// File: rtl/pipeline_stall_controller_if.sv
// Stall-controller bundle between the hazard/branch/memory sources and the
// pipeline-register enables.
//   master : drives the requests (hazard_stall_req, branch_taken, jump,
//            mem_busy, err_clear) and observes enables, counters and flags.
//   slave  : the stall controller; consumes requests, drives enables,
//            flush/bubble, the saturating counters and the sticky flags.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             hazard_stall_req;
  logic             branch_taken;
  logic             jump;
  logic             mem_busy;
  logic             err_clear;
  logic             pc_enable;
  logic             ifid_enable;
  logic             ifid_flush;
  logic             idex_enable;
  logic             idex_bubble;
  logic             exmem_enable;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic             stall_overrun;
  logic             mem_timeout;

  modport master (
    output hazard_stall_req, branch_taken, jump, mem_busy, err_clear,
    input  pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
           exmem_enable, stall_cycles, flush_events, stall_overrun, mem_timeout
  );

  modport slave (
    input  hazard_stall_req, branch_taken, jump, mem_busy, err_clear,
    output pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
           exmem_enable, stall_cycles, flush_events, stall_overrun, mem_timeout
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for the 5-stage core.
// Resolves memory wait, branch, load-use stall and jump (in that priority)
// into PC/IF-ID/ID-EX/EX-MEM enables, IF/ID flush and ID/EX bubble. Control
// outputs are combinational; event counters and sticky flags are registered.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of pipeline_stall_controller_if (requests in,
//           enables/flush/bubble, stall_cycles, flush_events,
//           stall_overrun, mem_timeout out)
module pipeline_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MAX_STALL   = 2,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_stall_controller_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int RUN_W  = $clog2(MAX_STALL + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_STALL + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      run_cnt_q   <= run_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and counter update, priority mem > branch > stall > jump
  always_comb begin
    state_d   = RUN;
    flush_evt = 1'b0;
    if (bus.mem_busy) begin
      state_d = MEMWAIT;
    end else if (bus.branch_taken) begin
      flush_evt = 1'b1;
    end else if (bus.hazard_stall_req) begin
      state_d = STALL;
    end else if (bus.jump) begin
      flush_evt = 1'b1;
    end

    // A wait run starts at 1 on entry and counts while frozen.
    wait_cnt_d = '0;
    if (state_d == MEMWAIT)
      wait_cnt_d = (state_q == MEMWAIT) ? sat_inc_wait(wait_cnt_q) : WAIT_W'(1);

    // The freeze holds the stall run length: the same load-use instruction
    // is still waiting when memory releases the pipeline.
    run_cnt_d = '0;
    if (state_d == STALL)
      run_cnt_d = (state_q == RUN) ? RUN_W'(1) : sat_inc_run(run_cnt_q);
    else if (state_d == MEMWAIT)
      run_cnt_d = run_cnt_q;

    stall_cnt_d = (state_d == STALL) ? sat_inc_cnt(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_evt ? sat_inc_cnt(flush_cnt_q) : flush_cnt_q;

    // Flags set only on the cycle the threshold is first reached; a set
    // condition beats a simultaneous clear.
    overrun_d = overrun_q & ~bus.err_clear;
    if (state_d == STALL && run_cnt_q != RUN_MAX && run_cnt_d == RUN_MAX)
      overrun_d = 1'b1;
    timeout_d = timeout_q & ~bus.err_clear;
    if (state_d == MEMWAIT && wait_cnt_q != WAIT_MAX && wait_cnt_d == WAIT_MAX)
      timeout_d = 1'b1;
  end

  // Output decode
  always_comb begin
    bus.pc_enable    = 1'b1;
    bus.ifid_enable  = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_enable  = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.exmem_enable = 1'b1;
    if (reset) begin
      bus.pc_enable    = 1'b0;
      bus.ifid_enable  = 1'b0;
      bus.ifid_flush   = 1'b1;
      bus.idex_enable  = 1'b0;
      bus.idex_bubble  = 1'b1;
      bus.exmem_enable = 1'b0;
    end else if (bus.mem_busy) begin
      bus.pc_enable    = 1'b0;
      bus.ifid_enable  = 1'b0;
      bus.idex_enable  = 1'b0;
      bus.exmem_enable = 1'b0;
    end else if (bus.branch_taken) begin
      bus.ifid_flush   = 1'b1;
      bus.idex_bubble  = 1'b1;
    end else if (bus.hazard_stall_req) begin
      bus.pc_enable    = 1'b0;
      bus.ifid_enable  = 1'b0;
      bus.idex_bubble  = 1'b1;
    end else if (bus.jump) begin
      bus.ifid_flush   = 1'b1;
    end
  end

  assign bus.stall_cycles  = stall_cnt_q;
  assign bus.flush_events  = flush_cnt_q;
  assign bus.stall_overrun = overrun_q;
  assign bus.mem_timeout   = timeout_q;

endmodule
